// File: rtl/nor_gate_sweep_ctrl.sv
// nor_gate_sweep_ctrl: sweeps every op/vector of the gate unit and checks y against a truth table
module nor_gate_sweep_ctrl #(
  parameter int NUM_OPS = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic [2:0] op,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [2:0] first_fail_op,
  output logic [1:0] first_fail_vec
);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC - 1);
  // Expected y, indexed by {op,a,b}; ops 7..0 from BUF a down to AND
  localparam logic [31:0] TT = {4'b1100, 4'b0011, 4'b1001, 4'b0110,
                                4'b0001, 4'b0111, 4'b1110, 4'b1000};
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic miss, last;
  logic [5:0] err_nx;
  assign miss = y != TT[{op, a, b}];
  assign err_nx = err_cnt + {5'd0, miss && err_cnt != 6'd63};
  assign last = {a, b} == 2'b11 && op == 3'(NUM_OPS - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      {op, a, b} <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_cnt <= '0;
      first_fail_op <= '0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          state <= SETTLE;
          busy <= 1'b1;
          {op, a, b} <= '0;
          err_cnt <= '0;
          first_fail_op <= '0;
          first_fail_vec <= '0;
          cnt <= RELOAD;
        end
        SETTLE: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          {op, a, b} <= '0;
        end else if (cnt == '0) state <= CHECK;
        else cnt <= cnt - 1'b1;
        CHECK: if (abort) begin
          state <= IDLE;
          busy <= 1'b0;
          {op, a, b} <= '0;
        end else begin
          err_cnt <= err_nx;
          if (miss && err_cnt == '0) begin
            first_fail_op <= op;
            first_fail_vec <= {a, b};
          end
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_nx == '0;
            {op, a, b} <= '0;
          end else begin
            state <= SETTLE;
            {op, a, b} <= {op, a, b} + 5'd1;
            cnt <= RELOAD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
